// File: rtl/fifo_byte_serializer.sv
// rtl/fifo_byte_serializer.sv - drains 24-bit FIFO words into a valid/ready byte stream
module fifo_byte_serializer #(
    parameter int DATA_W    = 24,
    parameter bit MSB_FIRST = 1'b1,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    output logic [7:0]         byte_out,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SEND
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          byte_idx;
    logic [1:0]          byte_idx_next;
    logic [DATA_W-1:0]   hold_reg;
    logic [DATA_W-1:0]   hold_next;
    logic [COUNT_W-1:0]  count_next;
    logic [1:0]          lane;
    logic                handshake;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            byte_idx   <= 2'd0;
            hold_reg   <= '0;
            word_count <= '0;
        end else begin
            state      <= state_next;
            byte_idx   <= byte_idx_next;
            hold_reg   <= hold_next;
            word_count <= count_next;
        end
    end

    assign handshake = byte_valid && byte_ready;

    // fifo_empty is only consulted in IDLE and on the last-byte handshake,
    // so a read strobe can never follow an empty indication.
    always_comb begin
        state_next    = state;
        byte_idx_next = byte_idx;
        hold_next     = hold_reg;
        count_next    = word_count;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                hold_next     = fifo_data;
                byte_idx_next = 2'd0;
                state_next    = SEND;
            end
            SEND: begin
                if (handshake) begin
                    if (byte_idx == 2'd2) begin
                        count_next    = word_count + COUNT_W'(1);
                        byte_idx_next = 2'd0;
                        state_next    = fifo_empty ? IDLE : FETCH;
                    end else begin
                        byte_idx_next = byte_idx + 2'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fifo_rd_en = (state == FETCH);
    assign byte_valid = (state == SEND);
    assign busy       = (state != IDLE);

    // lane 2 is the most significant byte of the holding register
    assign lane = MSB_FIRST ? (2'd2 - byte_idx) : byte_idx;

    always_comb begin
        byte_out = 8'd0;
        case (lane)
            2'd0:    byte_out = hold_reg[7:0];
            2'd1:    byte_out = hold_reg[15:8];
            2'd2:    byte_out = hold_reg[23:16];
            default: byte_out = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb/tb_fifo_byte_serializer.sv - directed self-checking bench for fifo_byte_serializer
module tb_fifo_byte_serializer;

    logic        clk = 1'b0;
    logic        reset;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    logic [23:0] fifo_data_a;
    logic        fifo_empty_a;
    logic        rd_en_a;
    logic [7:0]  byte_out_a;
    logic        byte_valid_a;
    logic        byte_ready_a;
    logic        busy_a;
    logic [15:0] word_count_a;

    logic [23:0] fifo_data_b;
    logic        fifo_empty_b;
    logic        rd_en_b;
    logic [7:0]  byte_out_b;
    logic        byte_valid_b;
    logic        byte_ready_b;
    logic        busy_b;
    logic [3:0]  word_count_b;

    fifo_byte_serializer #(.DATA_W(24), .MSB_FIRST(1'b1), .COUNT_W(16)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .fifo_data  (fifo_data_a),
        .fifo_empty (fifo_empty_a),
        .fifo_rd_en (rd_en_a),
        .byte_out   (byte_out_a),
        .byte_valid (byte_valid_a),
        .byte_ready (byte_ready_a),
        .busy       (busy_a),
        .word_count (word_count_a)
    );

    fifo_byte_serializer #(.DATA_W(24), .MSB_FIRST(1'b0), .COUNT_W(4)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .fifo_data  (fifo_data_b),
        .fifo_empty (fifo_empty_b),
        .fifo_rd_en (rd_en_b),
        .byte_out   (byte_out_b),
        .byte_valid (byte_valid_b),
        .byte_ready (byte_ready_b),
        .busy       (busy_b),
        .word_count (word_count_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: data_out is valid the cycle after rd_en is sampled
    logic [23:0] mem_a [0:63];
    logic [23:0] mem_b [0:63];
    int wr_a = 0, rd_a = 0, err_a = 0;
    int wr_b = 0, rd_b = 0, err_b = 0;
    assign fifo_empty_a = (wr_a == rd_a);
    assign fifo_empty_b = (wr_b == rd_b);

    always @(posedge clk) begin
        if (rd_en_a) begin
            if (wr_a == rd_a) err_a <= err_a + 1;
            else begin
                fifo_data_a <= mem_a[rd_a % 64];
                rd_a        <= rd_a + 1;
            end
        end
        if (rd_en_b) begin
            if (wr_b == rd_b) err_b <= err_b + 1;
            else begin
                fifo_data_b <= mem_b[rd_b % 64];
                rd_b        <= rd_b + 1;
            end
        end
    end

    int          rd_log_a[$];
    int          bcyc_a[$];
    logic [7:0]  byte_log_a[$];
    logic [7:0]  byte_log_b[$];

    always @(negedge clk) begin
        #3;
        if (!reset) begin
            if (rd_en_a) rd_log_a.push_back(cyc);
            if (byte_valid_a && byte_ready_a) begin
                byte_log_a.push_back(byte_out_a);
                bcyc_a.push_back(cyc);
            end
            if (byte_valid_b && byte_ready_b) byte_log_b.push_back(byte_out_b);
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_a(input logic [23:0] d);
        mem_a[wr_a % 64] = d;
        wr_a = wr_a + 1;
    endtask

    task automatic push_b(input logic [23:0] d);
        mem_b[wr_b % 64] = d;
        wr_b = wr_b + 1;
    endtask

    task automatic clear_logs();
        rd_log_a.delete();
        bcyc_a.delete();
        byte_log_a.delete();
        byte_log_b.delete();
    endtask

    task automatic wait_idle_a(input int budget);
        int n = 0;
        step();
        while ((busy_a || !fifo_empty_a) && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL wait_idle_a: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic wait_idle_b(input int budget);
        int n = 0;
        step();
        while ((busy_b || !fifo_empty_b) && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL wait_idle_b: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        byte_ready_a = 1'b1;
        byte_ready_b = 1'b1;
        step();
        step();
        tests++; if (rd_en_a !== 1'b0)       begin fails++; $display("FAIL reset_rd_en: got %b required 0", rd_en_a); end
        tests++; if (byte_valid_a !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b required 0", byte_valid_a); end
        tests++; if (byte_out_a !== 8'h00)   begin fails++; $display("FAIL reset_byte: got %h required 00", byte_out_a); end
        tests++; if (busy_a !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b required 0", busy_a); end
        tests++; if (word_count_a !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d required 0", word_count_a); end
        tests++; if (byte_valid_b !== 1'b0 || busy_b !== 1'b0 || word_count_b !== 4'd0 || byte_out_b !== 8'h00)
            begin fails++; $display("FAIL reset_b: got valid=%b busy=%b cnt=%0d byte=%h required all 0", byte_valid_b, busy_b, word_count_b, byte_out_b); end
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        int t0;
        logic [7:0] exp_b [3];
        exp_b = '{8'hAB, 8'hCD, 8'hEF};
        clear_logs();
        step();
        push_a(24'hABCDEF);
        t0 = cyc;
        wait_idle_a(40);
        repeat (5) step();
        tests++; if (rd_log_a.size() != 1) begin fails++; $display("FAIL single_rd_pulses: got %0d required 1", rd_log_a.size()); end
        tests++;
        if (byte_log_a.size() != 3) begin
            fails++; $display("FAIL single_byte_count: got %0d required 3", byte_log_a.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (byte_log_a[i] !== exp_b[i]) begin fails++; $display("FAIL single_byte%0d: got %h required %h", i, byte_log_a[i], exp_b[i]); end
            end
            tests++; if (bcyc_a[0] - t0 != 3) begin fails++; $display("FAIL single_latency: got %0d required 3", bcyc_a[0] - t0); end
            tests++; if (bcyc_a[2] - bcyc_a[0] != 2) begin fails++; $display("FAIL single_consecutive: got span %0d required 2", bcyc_a[2] - bcyc_a[0]); end
        end
        tests++; if (word_count_a !== 16'd1) begin fails++; $display("FAIL single_count: got %0d required 1", word_count_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL single_busy: got %b required 0", busy_a); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        clear_logs();
        step();
        push_a(24'h123456);
        step();
        while (!(byte_valid_a && byte_out_a == 8'h34) && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (n >= 20) begin
            fails++; $display("FAIL bp_find34: byte 34 not presented within 20 cycles");
        end
        byte_ready_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            tests++;
            if (byte_out_a !== 8'h34 || byte_valid_a !== 1'b1 || rd_en_a !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d: got byte=%h valid=%b rd_en=%b required 34/1/0", i, byte_out_a, byte_valid_a, rd_en_a);
            end
        end
        byte_ready_a = 1'b1;
        step();
        tests++; if (byte_out_a !== 8'h56 || byte_valid_a !== 1'b1) begin fails++; $display("FAIL bp_next: got byte=%h valid=%b required 56/1", byte_out_a, byte_valid_a); end
        wait_idle_a(20);
        tests++; if (rd_log_a.size() != 1) begin fails++; $display("FAIL bp_rd_pulses: got %0d required 1", rd_log_a.size()); end
        tests++; if (byte_log_a.size() != 3) begin fails++; $display("FAIL bp_byte_count: got %0d required 3", byte_log_a.size()); end
        tests++; if (word_count_a !== 16'd2) begin fails++; $display("FAIL bp_count: got %0d required 2", word_count_a); end
    endtask

    task automatic test_burst();
        clear_logs();
        step();
        for (int i = 0; i < 16; i++) push_a(24'(i));
        wait_idle_a(200);
        tests++;
        if (byte_log_a.size() != 48) begin
            fails++; $display("FAIL burst_byte_count: got %0d required 48", byte_log_a.size());
        end else begin
            for (int i = 0; i < 48; i++) begin
                logic [7:0] e;
                e = (i % 3 == 2) ? 8'(i / 3) : 8'h00;
                tests++;
                if (byte_log_a[i] !== e) begin fails++; $display("FAIL burst_byte%0d: got %h required %h", i, byte_log_a[i], e); end
            end
        end
        tests++;
        if (rd_log_a.size() != 16) begin
            fails++; $display("FAIL burst_rd_pulses: got %0d required 16", rd_log_a.size());
        end else begin
            for (int i = 1; i < 16; i++) begin
                tests++;
                if (rd_log_a[i] - rd_log_a[i-1] != 5) begin fails++; $display("FAIL burst_spacing%0d: got %0d required 5", i, rd_log_a[i] - rd_log_a[i-1]); end
            end
            if (bcyc_a.size() == 48) begin
                tests++;
                if (bcyc_a[47] - rd_log_a[0] + 1 != 80) begin fails++; $display("FAIL burst_total: got %0d cycles required 80", bcyc_a[47] - rd_log_a[0] + 1); end
            end
        end
        tests++; if (err_a != 0) begin fails++; $display("FAIL burst_fifo_err: got %0d required 0", err_a); end
        tests++; if (word_count_a !== 16'd18) begin fails++; $display("FAIL burst_count: got %0d required 18", word_count_a); end
    endtask

    task automatic test_reset_mid_send();
        int n = 0;
        logic [7:0] exp_b [6];
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h0C};
        clear_logs();
        step();
        push_a(24'hA5A5A5);
        step();
        while (byte_log_a.size() < 1 && n < 20) begin
            step();
            n++;
        end
        tests++; if (n >= 20) begin fails++; $display("FAIL mid_first_byte: byte 0 not accepted within 20 cycles"); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (byte_valid_a !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b required 0", byte_valid_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b required 0", busy_a); end
        tests++; if (word_count_a !== 16'd0) begin fails++; $display("FAIL mid_count: got %0d required 0", word_count_a); end
        tests++; if (byte_out_a !== 8'h00 || rd_en_a !== 1'b0) begin fails++; $display("FAIL mid_outputs: got byte=%h rd_en=%b required 00/0", byte_out_a, rd_en_a); end
        clear_logs();
        push_a(24'h010203);
        push_a(24'h0A0B0C);
        wait_idle_a(40);
        tests++;
        if (byte_log_a.size() != 6) begin
            fails++; $display("FAIL mid_drain_count: got %0d required 6", byte_log_a.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (byte_log_a[i] !== exp_b[i]) begin fails++; $display("FAIL mid_drain_byte%0d: got %h required %h", i, byte_log_a[i], exp_b[i]); end
            end
        end
        tests++; if (word_count_a !== 16'd2) begin fails++; $display("FAIL mid_drain_words: got %0d required 2", word_count_a); end
        tests++; if (err_a != 0) begin fails++; $display("FAIL mid_fifo_err: got %0d required 0", err_a); end
    endtask

    task automatic test_order_wrap();
        logic [7:0] exp_b [3];
        exp_b = '{8'h56, 8'h34, 8'h12};
        clear_logs();
        step();
        push_b(24'h123456);
        for (int i = 0; i < 16; i++) push_b({8'(i), 8'(i + 16), 8'(i + 32)});
        wait_idle_b(300);
        tests++;
        if (byte_log_b.size() != 51) begin
            fails++; $display("FAIL wrap_byte_count: got %0d required 51", byte_log_b.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (byte_log_b[i] !== exp_b[i]) begin fails++; $display("FAIL lsb_first_byte%0d: got %h required %h", i, byte_log_b[i], exp_b[i]); end
            end
            for (int w = 0; w < 16; w++) begin
                tests++;
                if (byte_log_b[3 + 3*w] !== 8'(w + 32) || byte_log_b[4 + 3*w] !== 8'(w + 16) || byte_log_b[5 + 3*w] !== 8'(w)) begin
                    fails++; $display("FAIL lsb_word%0d: got %h %h %h required %h %h %h", w,
                        byte_log_b[3 + 3*w], byte_log_b[4 + 3*w], byte_log_b[5 + 3*w], 8'(w + 32), 8'(w + 16), 8'(w));
                end
            end
        end
        tests++; if (word_count_b !== 4'd1) begin fails++; $display("FAIL wrap_count: got %0d required 1", word_count_b); end
        tests++; if (err_b != 0) begin fails++; $display("FAIL wrap_fifo_err: got %0d required 0", err_b); end
    endtask

    initial begin
        reset = 1'b1;
        byte_ready_a = 1'b1;
        byte_ready_b = 1'b1;
        test_reset();
        test_single_word();
        test_backpressure();
        test_burst();
        test_reset_mid_send();
        test_order_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_byte_serializer.md
Name: fifo_byte_serializer

Overview:
- Downstream drain stage for the 24-bit, 16-deep FIFO.
- Pops one 24-bit word at a time using the FIFO's rd_en/empty interface, then emits the word as three 8-bit bytes over a valid/ready byte stream.
- Never issues a read while the FIFO reports empty, so it cannot provoke the FIFO err flag.
- Keeps a running count of fully transmitted words.

Parameters:
- DATA_W, 24: FIFO word width; must equal 3*8.
- MSB_FIRST, 1: 1 = byte order [23:16],[15:8],[7:0]; 0 = [7:0],[15:8],[23:16].
- COUNT_W, 16: width of word_count; the counter wraps modulo 2^COUNT_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- fifo_data  in  24  FIFO data_out; valid on the cycle after the FIFO samples rd_en high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  read strobe to the FIFO; one-cycle pulse per word.
- byte_out  out  8  serialized byte.
- byte_valid  out  1  byte_out holds a valid byte.
- byte_ready  in  1  downstream accepts the byte; transfer occurs when byte_valid && byte_ready at the rising edge.
- busy  out  1  high whenever state != IDLE.
- word_count  out  COUNT_W  number of words whose third byte has been accepted.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered or decoded from registered state only.
- Reset values: fifo_rd_en=0, byte_valid=0, byte_out=0, busy=0, word_count=0, state=IDLE, byte_idx=0, holding register=0.
- IDLE: if !fifo_empty, go to FETCH; otherwise stay.
- FETCH: fifo_rd_en=1 for exactly this cycle; next state is CAPTURE.
- CAPTURE: fifo_rd_en=0; at the end of the cycle, latch fifo_data into the 24-bit holding register and set byte_idx=0; next state is SEND.
- SEND: byte_valid=1; byte_out = holding-register byte selected by byte_idx and MSB_FIRST.
- Handshake in SEND, when byte_valid && byte_ready:
  - If byte_idx<2: byte_idx increments.
  - If byte_idx==2: word_count increments; next state is FETCH if !fifo_empty, else IDLE.
- Back-pressure: while byte_valid && !byte_ready, byte_out and byte_idx hold; no FIFO read occurs.
- fifo_empty is sampled only in IDLE and on the final-byte handshake. fifo_rd_en is never high when fifo_empty was high in the deciding cycle.
- Throughput with byte_ready held at 1: 5 cycles per word (FETCH, CAPTURE, 3x SEND). Latency from fifo_empty falling in IDLE to the first byte_valid is 3 cycles.
- word_count wraps from 2^COUNT_W-1 to 0 with no flag.
- byte_valid never drops before its handshake completes, except on reset.
- Reset mid-operation: the next cycle is in IDLE with all outputs at reset values. A word already popped from the FIFO is discarded; this is accepted behaviour.
- fifo_data is ignored outside CAPTURE.

Test Plan:
- Reset: assert reset for 2 cycles with arbitrary inputs -> fifo_rd_en=0, byte_valid=0, byte_out=0, busy=0, word_count=0.
- Single word, MSB_FIRST=1, byte_ready=1:
  - Stimulus: FIFO holds 0xABCDEF.
  - Response: exactly one fifo_rd_en pulse; bytes 0xAB, 0xCD, 0xEF on 3 consecutive cycles; word_count=1; busy returns to 0; no further rd_en while fifo_empty=1.
- Back-pressure:
  - Stimulus: word 0x123456; byte_ready=0 for 4 cycles once byte 0x34 is presented.
  - Response: byte_out stays 0x34 with byte_valid=1 throughout; no rd_en pulse; 0x56 follows the first ready cycle.
- Burst drain:
  - Stimulus: FIFO filled with 16 words 0..15, byte_ready=1.
  - Response: 48 bytes 00,00,00,00,00,01,...,00,00,0F in order; 16 rd_en pulses, spaced 5 cycles apart; total 80 cycles; FIFO err never asserted; word_count=16.
- Reset mid-SEND:
  - Stimulus: assert reset after byte 0 of 0xA5A5A5 is accepted.
  - Response: next cycle byte_valid=0, busy=0, word_count=0; subsequent FIFO words are drained normally.
- Byte order and wrap:
  - Stimulus: MSB_FIRST=0, COUNT_W=4; send 0x123456, then 16 more words.
  - Response: first word emits 0x56, 0x34, 0x12; word_count reads 1 after 17 words (wrapped).
